// File: rtl/sc_player_pkg.sv
// Shared player-2 command encodings and direction-FSM state type.
// The position register reuses the CMD_* encodings.
package sc_player_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCK
    } dir_state_t;

endpackage

// File: rtl/sc_button_debouncer.sv
// Two-flop synchroniser plus debouncer for one active-low pushbutton.
// Produces the debounced pressed level and a one-cycle press-edge pulse.
module sc_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pressed,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          press_q;

    // level keeps the raw button polarity: 1 = released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            level   <= 1'b1;
            cnt     <= '0;
            press_q <= 1'b0;
        end else begin
            sync    <= {sync[0], button};
            press_q <= 1'b0;
            if (sync[1] != level) begin
                if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                    level   <= sync[1];
                    cnt     <= '0;
                    press_q <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pressed = ~level;
    assign press   = press_q;

endmodule

// File: rtl/sc_player_2_move_controller.sv
// Player-2 button front end: debounced start load strobe and
// hold-to-repeat left/right shift commands for the position register.
module sc_player_2_move_controller
    import sc_player_pkg::*;
#(
    parameter int unsigned DATAWIDTH       = 8,
    parameter logic [DATAWIDTH-1:0] INIT_POSITION = {{(DATAWIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_CLOCK_50,
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_RESET_InLow,
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_enable_InHigh,
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_start_InLow,
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_left_InLow,
    input  logic                 SC_PLAYER_2_MOVE_CONTROLLER_right_InLow,
    output logic                 SC_PLAYER_2_MOVE_CONTROLLER_load_OutLow,
    output logic [1:0]           SC_PLAYER_2_MOVE_CONTROLLER_shiftselection_Out,
    output logic [DATAWIDTH-1:0] SC_PLAYER_2_MOVE_CONTROLLER_data_OutBUS
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    logic clk, rst_n, enable;
    assign clk    = SC_PLAYER_2_MOVE_CONTROLLER_CLOCK_50;
    assign rst_n  = SC_PLAYER_2_MOVE_CONTROLLER_RESET_InLow;
    assign enable = SC_PLAYER_2_MOVE_CONTROLLER_enable_InHigh;

    logic start_level, start_press;
    logic left_level, left_press;
    logic right_level, right_press;

    sc_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst_n(rst_n), .button(SC_PLAYER_2_MOVE_CONTROLLER_start_InLow),
        .pressed(start_level), .press(start_press)
    );
    sc_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .rst_n(rst_n), .button(SC_PLAYER_2_MOVE_CONTROLLER_left_InLow),
        .pressed(left_level), .press(left_press)
    );
    sc_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .rst_n(rst_n), .button(SC_PLAYER_2_MOVE_CONTROLLER_right_InLow),
        .pressed(right_level), .press(right_press)
    );

    // Directions act on levels (a held button re-arms when enable rises)
    logic unused_debounce;
    assign unused_debounce = ^{start_level, left_press, right_press};

    dir_state_t    state, state_n;
    logic [RW-1:0] cnt, cnt_n;
    logic [RW-1:0] limit;
    logic [1:0]    dir, dir_n;
    logic [1:0]    shift_q, shift_n;
    logic          load_q;
    logic          held, both;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dir     <= CMD_NONE;
            shift_q <= CMD_NONE;
            load_q  <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dir     <= dir_n;
            shift_q <= shift_n;
            load_q  <= ~start_press;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        shift_n = CMD_NONE;
        both    = left_level & right_level;
        held    = (dir == CMD_LEFT) ? left_level : right_level;
        limit   = (state == ST_REPEAT) ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (both) begin
                        state_n = ST_LOCK;
                    end else if (left_level || right_level) begin
                        dir_n   = left_level ? CMD_LEFT : CMD_RIGHT;
                        shift_n = dir_n;
                        state_n = ST_FIRST;
                        cnt_n   = RW'(1);
                    end
                end
                // cnt holds cycles elapsed since the most recent pulse
                ST_FIRST, ST_DELAY, ST_REPEAT: begin
                    if (both) begin
                        state_n = ST_LOCK;
                        cnt_n   = '0;
                    end else if (!held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt >= limit) begin
                        shift_n = dir;
                        state_n = ST_REPEAT;
                        cnt_n   = RW'(1);
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        state_n = (state == ST_REPEAT) ? ST_REPEAT : ST_DELAY;
                    end
                end
                ST_LOCK: begin
                    if (!left_level && !right_level) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (start_press && shift_n != CMD_NONE) begin
            shift_n = CMD_NONE;
            state_n = ST_IDLE;
            cnt_n   = '0;
        end
    end

    assign SC_PLAYER_2_MOVE_CONTROLLER_load_OutLow        = load_q;
    assign SC_PLAYER_2_MOVE_CONTROLLER_shiftselection_Out = shift_q;
    assign SC_PLAYER_2_MOVE_CONTROLLER_data_OutBUS        = INIT_POSITION;

endmodule
